da_seq: RTL and testbench

- Host-side sequencer for the `da` distributed-arithmetic FIR core. It plays the writer/initiator role on the core's coefficient-load and sample interfaces.
- Phase 1 (LOAD): streams 2048 precomputed 20-bit ROM words into the core over CADDR/CIN/CLOAD/valid_in.
- Phase 2 (RUN): frames incoming 8-lane sample words into jobs of 16 iterations × 12 cycles, generating `start` and `reset` to the core.
- Captures each job's 39-bit ACC_OUT result and returns it to the host over a valid/ready result port.

---
 rtl/da_pkg.sv | 23 ++
 rtl/da_frame_ctr.sv | 56 +++++
 rtl/da_seq.sv | 206 ++++++++++++++++++++
 tb/tb_da_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared parameters and state encoding for the da_seq host-side sequencer.
package da_pkg;

  localparam int ROM_WORDS    = 2048;  // coefficient words per full load
  localparam int CADDR_W      = 11;    // core ROM address width
  localparam int CIN_W        = 20;    // coefficient word width
  localparam int ACC_W        = 39;    // core accumulator width
  localparam int SMP_W        = 64;    // eight 8-bit sample lanes
  localparam int FRAME_CYCLES = 12;    // slots per iteration
  localparam int FRAME_ITERS  = 16;    // iterations per job
  localparam int RES_LAT      = 1;     // edges from end of last slot to capture
  localparam int CYC_W        = 4;
  localparam int ITER_W       = 4;
  localparam int DRAIN_W      = 2;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/da_frame_ctr.sv
// Cycle/iteration counter that frames sample slots into jobs.
module da_frame_ctr
  import da_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              clear,
  output logic [CYC_W-1:0]  cycle,
  output logic [ITER_W-1:0] iteration,
  output logic              first_slot,
  output logic              last_slot
);

  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic [ITER_W-1:0] iter_q, iter_d;

  // Advance one slot per step; wrap cycle into iteration and the job back to 0.
  always_comb begin
    cycle_d = cycle_q;
    iter_d  = iter_q;
    if (clear) begin
      cycle_d = '0;
      iter_d  = '0;
    end else if (step) begin
      if (cycle_q == CYC_W'(FRAME_CYCLES - 1)) begin
        cycle_d = '0;
        if (iter_q == ITER_W'(FRAME_ITERS - 1)) begin
          iter_d = '0;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end else begin
        cycle_d = cycle_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      iter_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      iter_q  <= iter_d;
    end
  end

  assign cycle      = cycle_q;
  assign iteration  = iter_q;
  assign first_slot = (cycle_q == '0) && (iter_q == '0);
  assign last_slot  = (cycle_q == CYC_W'(FRAME_CYCLES - 1)) &&
                      (iter_q == ITER_W'(FRAME_ITERS - 1));

endmodule

// File: rtl/da_seq.sv
// Host-side sequencer for the da FIR core: coefficient load, job framing,
// and result capture/return.
module da_seq
  import da_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cf_valid,
  input  logic [CIN_W-1:0]   cf_data,
  output logic               cf_ready,
  input  logic               smp_valid,
  input  logic [SMP_W-1:0]   smp_data,
  output logic               smp_ready,
  output logic               res_valid,
  output logic [ACC_W-1:0]   res_data,
  input  logic               res_ready,
  input  logic               reload,
  output logic               load_done,
  output logic               err,
  output logic [CADDR_W-1:0] da_caddr,
  output logic [CIN_W-1:0]   da_cin,
  output logic               da_cload,
  output logic               da_valid_in,
  output logic [SMP_W-1:0]   da_a,
  output logic               da_start,
  output logic               da_reset,
  input  logic [ACC_W-1:0]   da_acc_out,
  input  logic               da_valid_out
);

  state_t               state_q, state_d;
  logic [CADDR_W-1:0]   load_cnt_q, load_cnt_d;
  logic                 load_done_q, load_done_d;
  logic                 err_q, err_d;
  logic                 reload_pend_q, reload_pend_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [ACC_W-1:0]     res_data_q, res_data_d;
  logic [CADDR_W-1:0]   da_caddr_q, da_caddr_d;
  logic [CIN_W-1:0]     da_cin_q, da_cin_d;
  logic                 da_cload_q, da_cload_d;
  logic                 da_valid_in_q, da_valid_in_d;
  logic [SMP_W-1:0]     da_a_q, da_a_d;
  logic                 da_start_q, da_start_d;
  logic                 da_reset_q, da_reset_d;

  logic                 step, clear;
  logic [CYC_W-1:0]     cycle;
  logic [ITER_W-1:0]    iteration;
  logic                 first_slot, last_slot;
  logic                 reload_eff, honour_reload;

  // The core signals completion purely by timing, so its valid_out and the
  // raw iteration index are not needed here.
  logic unused_sigs;
  assign unused_sigs = ^{da_valid_out, iteration};

  da_frame_ctr u_frame_ctr (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .clear      (clear),
    .cycle      (cycle),
    .iteration  (iteration),
    .first_slot (first_slot),
    .last_slot  (last_slot)
  );

  // A reload request survives until the sequencer reaches an idle job boundary.
  assign reload_eff    = reload || reload_pend_q;
  assign honour_reload = (state_q == ST_RUN) && first_slot && !res_valid_q && reload_eff;

  // Handshake readies; a new job may not start while a result is unread or a
  // reload is about to take over the boundary.
  assign cf_ready  = (state_q == ST_LOAD) && !reset;
  assign smp_ready = (state_q == ST_RUN) && !(first_slot && (res_valid_q || reload_eff));

  // Next-state and registered-output computation for the sequencer FSM.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    load_done_d   = load_done_q;
    err_d         = err_q;
    reload_pend_d = reload_pend_q || (reload && (state_q != ST_LOAD));
    drain_cnt_d   = drain_cnt_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    da_caddr_d    = da_caddr_q;
    da_cin_d      = da_cin_q;
    da_cload_d    = 1'b0;
    da_valid_in_d = 1'b0;
    da_a_d        = '0;
    da_start_d    = 1'b0;
    da_reset_d    = 1'b0;
    step          = 1'b0;
    clear         = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (cf_valid) begin
          da_caddr_d    = load_cnt_q;
          da_cin_d      = cf_data;
          da_cload_d    = 1'b1;
          da_valid_in_d = 1'b1;
          if (load_cnt_q == CADDR_W'(ROM_WORDS - 1)) begin
            load_done_d = 1'b1;
            state_d     = ST_RUN;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (honour_reload) begin
          load_done_d   = 1'b0;
          load_cnt_d    = '0;
          reload_pend_d = 1'b0;
          state_d       = ST_LOAD;
        end else if (smp_valid && smp_ready) begin
          step       = 1'b1;
          da_a_d     = smp_data;
          da_start_d = (cycle == '0);
          da_reset_d = first_slot;
          if (last_slot) begin
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end
        end else if (!first_slot) begin
          // Bit-serial core cannot stall: a missing word mid-job kills the job.
          err_d = 1'b1;
          clear = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(RES_LAT)) begin
          res_data_d  = da_acc_out;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_RUN;
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      load_cnt_q    <= '0;
      load_done_q   <= 1'b0;
      err_q         <= 1'b0;
      reload_pend_q <= 1'b0;
      drain_cnt_q   <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      da_caddr_q    <= '0;
      da_cin_q      <= '0;
      da_cload_q    <= 1'b0;
      da_valid_in_q <= 1'b0;
      da_a_q        <= '0;
      da_start_q    <= 1'b0;
      da_reset_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      load_done_q   <= load_done_d;
      err_q         <= err_d;
      reload_pend_q <= reload_pend_d;
      drain_cnt_q   <= drain_cnt_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      da_caddr_q    <= da_caddr_d;
      da_cin_q      <= da_cin_d;
      da_cload_q    <= da_cload_d;
      da_valid_in_q <= da_valid_in_d;
      da_a_q        <= da_a_d;
      da_start_q    <= da_start_d;
      da_reset_q    <= da_reset_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign load_done   = load_done_q;
  assign err         = err_q;
  assign da_caddr    = da_caddr_q;
  assign da_cin      = da_cin_q;
  assign da_cload    = da_cload_q;
  assign da_valid_in = da_valid_in_q;
  assign da_a        = da_a_q;
  assign da_start    = da_start_q;
  assign da_reset    = da_reset_q;

endmodule

// File: tb/tb_da_seq.sv
// Directed bench for da_seq: load, job framing, hold, underflow, reload, reset.
module tb_da_seq;
  import da_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               cf_valid;
  logic [CIN_W-1:0]   cf_data;
  logic               cf_ready;
  logic               smp_valid;
  logic [SMP_W-1:0]   smp_data;
  logic               smp_ready;
  logic               res_valid;
  logic [ACC_W-1:0]   res_data;
  logic               res_ready;
  logic               reload;
  logic               load_done;
  logic               err;
  logic [CADDR_W-1:0] da_caddr;
  logic [CIN_W-1:0]   da_cin;
  logic               da_cload;
  logic               da_valid_in;
  logic [SMP_W-1:0]   da_a;
  logic               da_start;
  logic               da_reset;
  logic [ACC_W-1:0]   da_acc_out;
  logic               da_valid_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  da_seq dut (
    .clk          (clk),
    .reset        (reset),
    .cf_valid     (cf_valid),
    .cf_data      (cf_data),
    .cf_ready     (cf_ready),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .smp_ready    (smp_ready),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .reload       (reload),
    .load_done    (load_done),
    .err          (err),
    .da_caddr     (da_caddr),
    .da_cin       (da_cin),
    .da_cload     (da_cload),
    .da_valid_in  (da_valid_in),
    .da_a         (da_a),
    .da_start     (da_start),
    .da_reset     (da_reset),
    .da_acc_out   (da_acc_out),
    .da_valid_out (da_valid_out)
  );

  // Sends n contiguous sample words starting at a job boundary and checks
  // the per-slot core outputs; reload is pulsed on slot reload_at.
  task automatic send_slots(input int n, input int reload_at);
    int starts;
    logic [SMP_W-1:0] exp_a;
    logic exp_start, exp_rst;
    starts = 0;
    for (int k = 0; k < n; k++) begin
      exp_a     = {32'(k * 7 + 3), 32'(32'hA5A5_0000 + k)};
      smp_valid = 1'b1;
      smp_data  = exp_a;
      reload    = (k == reload_at);
      total++;
      if (smp_ready !== 1'b1) begin
        bad++;
        $display("FAIL slot_ready k=%0d got=%b want=1", k, smp_ready);
      end
      @(posedge clk); #1;
      exp_start = ((k % 12) == 0);
      exp_rst   = (k == 0);
      total++;
      if (da_a !== exp_a || da_start !== exp_start || da_reset !== exp_rst) begin
        bad++;
        $display("FAIL slot_out k=%0d got a=%h st=%b rs=%b want a=%h st=%b rs=%b",
                 k, da_a, da_start, da_reset, exp_a, exp_start, exp_rst);
      end
      if (da_start === 1'b1) starts++;
    end
    smp_valid = 1'b0;
    reload    = 1'b0;
    if (n == 192) begin
      total++;
      if (starts != 16) begin
        bad++;
        $display("FAIL start_count got=%0d want=16", starts);
      end
    end
  endtask

  // Expects no result at E+192 and the captured result at E+193.
  task automatic wait_result(input logic [ACC_W-1:0] exp);
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL res_early got=%b want=0", res_valid);
    end
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b1 || res_data !== exp) begin
      bad++;
      $display("FAIL res_capture got v=%b d=%h want v=1 d=%h", res_valid, res_data, exp);
    end
    $display("job result d=%h", res_data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cf_ready, smp_ready, res_valid, load_done, err, da_cload, da_valid_in,
         da_start, da_reset} !== 9'b0 || da_caddr !== '0 || da_a !== '0 || res_data !== '0) begin
      bad++;
      $display("FAIL reset_outs cf=%b sr=%b rv=%b ld=%b want all 0", cf_ready, smp_ready, res_valid, load_done);
    end
    reset = 1'b0;
    #1;
    total++;
    if (cf_ready !== 1'b1 || smp_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release cf=%b sr=%b want cf=1 sr=0", cf_ready, smp_ready);
    end
    $display("reset checked");
  endtask

  task automatic test_load();
    logic [CIN_W-1:0] exp_cin;
    for (int i = 0; i < ROM_WORDS; i++) begin
      exp_cin  = CIN_W'(i - 1024);
      cf_valid = 1'b1;
      cf_data  = exp_cin;
      @(posedge clk); #1;
      total++;
      if (da_cload !== 1'b1 || da_valid_in !== 1'b1 ||
          da_caddr !== CADDR_W'(i) || da_cin !== exp_cin) begin
        bad++;
        $display("FAIL load_word i=%0d got a=%0d c=%h cl=%b want a=%0d c=%h cl=1",
                 i, da_caddr, da_cin, da_cload, i, exp_cin);
      end
      if (i == ROM_WORDS - 2) begin
        total++;
        if (load_done !== 1'b0) begin
          bad++;
          $display("FAIL load_done_early got=%b want=0", load_done);
        end
      end
    end
    cf_valid = 1'b0;
    total++;
    if (load_done !== 1'b1 || cf_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_end ld=%b cf=%b want ld=1 cf=0", load_done, cf_ready);
    end
    @(posedge clk); #1;
    total++;
    if (da_cload !== 1'b0 || smp_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_after cl=%b sr=%b want cl=0 sr=1", da_cload, smp_ready);
    end
    $display("load of %0d words done", ROM_WORDS);
  endtask

  task automatic test_single_job();
    res_ready  = 1'b1;
    da_acc_out = -39'sd5;
    send_slots(192, -1);
    wait_result(39'h7F_FFFF_FFFB);
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0 || smp_ready !== 1'b1) begin
      bad++;
      $display("FAIL job_consume rv=%b sr=%b want rv=0 sr=1", res_valid, smp_ready);
    end
  endtask

  task automatic test_back_to_back();
    res_ready  = 1'b0;
    da_acc_out = -39'sd5;
    send_slots(192, -1);
    wait_result(39'h7F_FFFF_FFFB);
    da_acc_out = 39'd77;
    smp_valid  = 1'b1;
    smp_data   = 64'hDEAD_BEEF_0000_0001;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (smp_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_ready c=%0d got=%b want=0", c, smp_ready);
      end
      @(posedge clk); #1;
      total++;
      if (res_valid !== 1'b1 || res_data !== 39'h7F_FFFF_FFFB) begin
        bad++;
        $display("FAIL hold_data c=%0d got v=%b d=%h want v=1 d=7ffffffffb", c, res_valid, res_data);
      end
    end
    smp_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || smp_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_release rv=%b sr=%b want rv=0 sr=1", res_valid, smp_ready);
    end
    send_slots(192, -1);
    wait_result(39'd77);
    res_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL job2_consume got=%b want=0", res_valid);
    end
  endtask

  task automatic test_underflow();
    bit seen;
    res_ready = 1'b1;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_pre got=%b want=0", err);
    end
    send_slots(3 * 12 + 5, -1);
    @(posedge clk); #1;
    total++;
    if (err !== 1'b1 || da_a !== '0 || da_start !== 1'b0) begin
      bad++;
      $display("FAIL underflow err=%b a=%h st=%b want err=1 a=0 st=0", err, da_a, da_start);
    end
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (res_valid === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0 || smp_ready !== 1'b1) begin
      bad++;
      $display("FAIL underflow_nores seen=%b sr=%b want seen=0 sr=1", seen, smp_ready);
    end
    da_acc_out = 39'd1000;
    send_slots(192, -1);
    wait_result(39'd1000);
    @(posedge clk); #1;
    total++;
    if (err !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_sticky err=%b rv=%b want err=1 rv=0", err, res_valid);
    end
  endtask

  task automatic test_reload_deferred();
    int pulses;
    int addr;
    logic [CIN_W-1:0] exp_cin;
    res_ready  = 1'b0;
    da_acc_out = 39'd42;
    send_slots(192, 50);
    wait_result(39'd42);
    @(posedge clk); #1;
    total++;
    if (load_done !== 1'b1 || cf_ready !== 1'b0 || res_valid !== 1'b1) begin
      bad++;
      $display("FAIL reload_wait ld=%b cf=%b rv=%b want ld=1 cf=0 rv=1", load_done, cf_ready, res_valid);
    end
    smp_valid = 1'b1;
    smp_data  = 64'h1111_2222_3333_4444;
    res_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0 || smp_ready !== 1'b0 || cf_ready !== 1'b0) begin
      bad++;
      $display("FAIL reload_boundary rv=%b sr=%b cf=%b want 0 0 0", res_valid, smp_ready, cf_ready);
    end
    @(posedge clk); #1;
    smp_valid = 1'b0;
    res_ready = 1'b0;
    total++;
    if (cf_ready !== 1'b1 || load_done !== 1'b0 || da_start !== 1'b0 || da_reset !== 1'b0) begin
      bad++;
      $display("FAIL reload_taken cf=%b ld=%b st=%b want cf=1 ld=0 st=0", cf_ready, load_done, da_start);
    end
    pulses = 0;
    addr   = 0;
    for (int i = 0; i < 2 * ROM_WORDS; i++) begin
      cf_valid = ((i % 2) == 0);
      exp_cin  = CIN_W'(i * 3 + 1);
      cf_data  = exp_cin;
      @(posedge clk); #1;
      if (da_cload === 1'b1) pulses++;
      total++;
      if (cf_valid) begin
        if (da_cload !== 1'b1 || da_caddr !== CADDR_W'(addr) || da_cin !== exp_cin) begin
          bad++;
          $display("FAIL gap_word i=%0d got a=%0d cl=%b want a=%0d cl=1", i, da_caddr, da_cload, addr);
        end
        addr++;
      end else begin
        if (da_cload !== 1'b0 || da_caddr !== CADDR_W'(addr - 1)) begin
          bad++;
          $display("FAIL gap_hold i=%0d got a=%0d cl=%b want a=%0d cl=0", i, da_caddr, da_cload, addr - 1);
        end
      end
    end
    cf_valid = 1'b0;
    total++;
    if (pulses != ROM_WORDS || load_done !== 1'b1 || cf_ready !== 1'b0) begin
      bad++;
      $display("FAIL gap_load pulses=%0d ld=%b want pulses=%0d ld=1", pulses, load_done, ROM_WORDS);
    end
    $display("gapped reload: %0d cload pulses", pulses);
  endtask

  task automatic test_async_reset();
    res_ready = 1'b1;
    send_slots(96, -1);
    #3;
    reset  = 1'b1;
    reload = 1'b1;
    #1;
    total++;
    if ({cf_ready, smp_ready, res_valid, load_done, err, da_cload, da_valid_in,
         da_start, da_reset} !== 9'b0 || da_a !== '0 || da_caddr !== '0 || da_cin !== '0) begin
      bad++;
      $display("FAIL async_reset cf=%b sr=%b ld=%b err=%b st=%b a=%h want all 0",
               cf_ready, smp_ready, load_done, err, da_start, da_a);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    @(posedge clk); #1;
    reload = 1'b0;
    total++;
    if (cf_ready !== 1'b1 || smp_ready !== 1'b0 || load_done !== 1'b0 || da_cload !== 1'b0) begin
      bad++;
      $display("FAIL reset_to_load cf=%b sr=%b ld=%b cl=%b want 1 0 0 0", cf_ready, smp_ready, load_done, da_cload);
    end
    $display("async reset checked");
  endtask

  initial begin
    reset        = 1'b1;
    cf_valid     = 1'b0;
    cf_data      = '0;
    smp_valid    = 1'b0;
    smp_data     = '0;
    res_ready    = 1'b0;
    reload       = 1'b0;
    da_acc_out   = '0;
    da_valid_out = 1'b0;
    test_reset();
    test_load();
    test_single_job();
    test_back_to_back();
    test_underflow();
    test_reload_deferred();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
